motoro3_step_sequencer: RTL
===========================

Name: motoro3_step_sequencer

Overview:
Timebase and commutation sequencer for the 3-phase motor drive. It sits directly upstream of the PWM generator. Each cycle it produces the 12-position electrical step index sgStep, the per-step counter m3cnt, and the step-boundary strobes m3cntFirst1/2 and m3cntLast1/2. It also produces the gating signal pwmActive1 and a step-stable pwmLENpos, and handles run/stop requests so that stops land on whole electrical cycles.

Parameters:
CNT_W, 25, width of m3cnt and of the step-length register
STEP_MAX, 11, last sgStep value; the index wraps modulo STEP_MAX+1
LEN_MIN, 4, minimum step length in clocks; shorter requests are clamped to this

Ports:
clk  in  1  system clock, 10 MHz; all state updates on the falling edge, same edge as the PWM generator
rst  in  1  asynchronous, active-high reset
startReq  in  1  single-cycle run request
stopReq  in  1  single-cycle stop request
dirRev  in  1  0 = sgStep counts up, 1 = sgStep counts down; sampled only at step boundaries
m3r_stepLen  in  25  step length in clocks; sampled only at step boundaries
m3r_posPerPwm  in  16  PWM position increment; sampled only at step boundaries
pwmActive1  out  1  high while the sequencer is running
sgStep  out  4  current electrical step, 0..11
m3cnt  out  25  clocks elapsed within the current step
m3cntFirst1  out  1  high when m3cnt==0
m3cntFirst2  out  1  high when m3cnt==1
m3cntLast2  out  1  high when m3cnt==lenCur-2
m3cntLast1  out  1  high when m3cnt==lenCur-1
pwmLENpos  out  16  increment latched for the current step
cycleDone  out  1  one-cycle pulse when a stop completes

Behaviour:
- Reset values (rst high, asynchronous): state=IDLE, pwmActive1=0, sgStep=0, m3cnt=0, all strobes=0, pwmLENpos=0, cycleDone=0, lenCur=LEN_MIN, dirCur=0.
- States and transitions:
  - IDLE -> RUN when startReq=1.
  - RUN -> STOPPING when stopReq=1.
  - STOPPING -> IDLE at a cycle end (see below).
  - STOPPING -> RUN when startReq=1 arrives before the cycle end; this cancels the stop.
  - stopReq in IDLE is ignored. startReq in RUN is ignored.
- IDLE:
  - m3cnt=0, sgStep=0, all strobes=0, pwmActive1=0.
  - Every cycle, latch lenCur=max(m3r_stepLen, LEN_MIN), pwmLENpos=m3r_posPerPwm, and dirCur=dirRev.
- Entering RUN:
  - The first clock after startReq has pwmActive1=1, m3cnt=0, m3cntFirst1=1.
  - sgStep=0 when dirCur=0; sgStep=11 when dirCur=1.
- RUN and STOPPING, counting:
  - m3cnt increments each clock.
  - At m3cnt==lenCur-1 (the Last1 cycle), the next clock sets m3cnt=0.
  - On that same boundary, sgStep advances by +1 (dirCur=0) or -1 (dirCur=1), wrapping 11->0 and 0->11.
  - On that same boundary, lenCur, pwmLENpos and dirCur re-latch from their inputs.
- Strobes:
  - Strobes are registered, aligned with the m3cnt value they describe, and mutually exclusive. LEN_MIN=4 guarantees this.
  - m3cntLast1 is never asserted on the first cycle after start.
- Input changes to m3r_stepLen, m3r_posPerPwm or dirRev mid-step have no effect until the next boundary.
- Cycle end:
  - Forward (dirCur=0): the Last1 cycle of step 11.
  - Reverse (dirCur=1): the Last1 cycle of step 0.
  - In STOPPING at a cycle end, the next clock gives IDLE, pwmActive1=0, sgStep=0, m3cnt=0, and cycleDone=1 for one clock.
- Simultaneous startReq and stopReq: stopReq wins in RUN; startReq wins in STOPPING and in IDLE.
- rst asserted mid-step: immediate return to reset values. No cycleDone is issued.
- Arithmetic: lenCur-1 and lenCur-2 are computed at CNT_W width. The clamp guarantees no underflow. m3cnt never exceeds lenCur-1.

Decomposition:
- Shared package motoro3_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2);
  - STEP_MAX and LEN_MIN;
  - step-phase constants 4'd0, 4'd6 (phase-B/C pull steps) reused by the PWM generator.
- One natural sub-module, motoro3_step_timer: holds m3cnt, lenCur and the four strobes, and emits a boundary pulse. The top level owns the FSM, sgStep, pwmLENpos and dirCur.

Test Plan:
- Reset mid-run: rst pulse while sgStep=5, m3cnt=7 -> all outputs read reset values during rst, with no cycleDone pulse.
- Basic run: m3r_stepLen=10, startReq -> pwmActive1=1; strobe order First1 (m3cnt=0), First2 (1), Last2 (8), Last1 (9); sgStep runs 0,1,…,11,0; each step is exactly 10 clocks.
- Clamp: m3r_stepLen=2 -> each step is 4 clocks; strobes appear at m3cnt=0,1,2,3 with no overlap.
- Boundary sampling: change m3r_stepLen from 10 to 20 and m3r_posPerPwm from 0x0100 to 0x0200 at m3cnt=3 of step 2 -> step 2 stays 10 clocks and pwmLENpos stays 0x0100; step 3 is 20 clocks with pwmLENpos=0x0200.
- Reverse with wrap: dirRev=1 before start -> sgStep runs 11,10,…,0,11; dirRev toggled mid-step takes effect only at the next boundary.
- Stop handling: stopReq at sgStep=4 -> running continues through step 11 Last1, then pwmActive1=0, sgStep=0, and a single cycleDone pulse. Repeat with startReq at sgStep=9 during STOPPING -> no stop, sgStep continues 10, 11, 0, …

Source files
------------

// File: rtl/motoro3_pkg.sv
// motoro3_pkg
//   Definitions shared by the motor sequencer slice and the PWM generator:
//   state encoding, counter width, step range, minimum step length and the
//   phase-B/C pull step constants.
package motoro3_pkg;

  localparam int unsigned      CNT_W   = 25;
  localparam logic [3:0]       STEP_MAX = 4'd11;
  localparam logic [CNT_W-1:0] LEN_MIN = CNT_W'(4);

  // Steps where the PWM generator pulls phase B / phase C.
  localparam logic [3:0] STEP_PHASE_B = 4'd0;
  localparam logic [3:0] STEP_PHASE_C = 4'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } seqState_t;

  // Requests shorter than LEN_MIN would make the four strobes overlap.
  function automatic logic [CNT_W-1:0] clampLen(input logic [CNT_W-1:0] len);
    return (len < LEN_MIN) ? LEN_MIN : len;
  endfunction

  function automatic logic [3:0] nextStep(input logic [3:0] step, input logic rev);
    if (rev) return (step == 4'd0) ? STEP_MAX : step - 4'd1;
    return (step == STEP_MAX) ? 4'd0 : step + 4'd1;
  endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// motoro3_step_sequencer_if
//   Control and status bundle of the step sequencer.
//   master : run/stop requests and step configuration out, status in
//   slave  : the sequencer itself
interface motoro3_step_sequencer_if;
  import motoro3_pkg::*;

  logic             startReq;
  logic             stopReq;
  logic             dirRev;
  logic [CNT_W-1:0] m3r_stepLen;
  logic [15:0]      m3r_posPerPwm;

  logic             pwmActive1;
  logic [3:0]       sgStep;
  logic [CNT_W-1:0] m3cnt;
  logic             m3cntFirst1;
  logic             m3cntFirst2;
  logic             m3cntLast2;
  logic             m3cntLast1;
  logic [15:0]      pwmLENpos;
  logic             cycleDone;

  modport master (
    output startReq, stopReq, dirRev, m3r_stepLen, m3r_posPerPwm,
    input  pwmActive1, sgStep, m3cnt, m3cntFirst1, m3cntFirst2,
           m3cntLast2, m3cntLast1, pwmLENpos, cycleDone
  );

  modport slave (
    input  startReq, stopReq, dirRev, m3r_stepLen, m3r_posPerPwm,
    output pwmActive1, sgStep, m3cnt, m3cntFirst1, m3cntFirst2,
           m3cntLast2, m3cntLast1, pwmLENpos, cycleDone
  );
endinterface

// File: rtl/motoro3_step_timer.sv
// motoro3_step_timer
//   Per-step clock counter with registered boundary strobes.
//   clk, rst    : falling-edge clock, async active-high reset
//   idle        : sequencer idle, step length tracks stepLen every clock
//   restart     : sequencer enters RUN on the coming edge
//   activeNext  : sequencer is running after the coming edge
//   stepLen     : requested step length, sampled in idle and at boundaries
//   m3cnt       : clocks elapsed in the current step
//   first1/2, last2/1 : strobes for m3cnt == 0, 1, len-2, len-1
//   boundary    : current clock is the last one of the step
module motoro3_step_timer
  import motoro3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             idle,
  input  logic             restart,
  input  logic             activeNext,
  input  logic [CNT_W-1:0] stepLen,
  output logic [CNT_W-1:0] m3cnt,
  output logic             first1,
  output logic             first2,
  output logic             last2,
  output logic             last1,
  output logic             boundary
);

  logic [CNT_W-1:0] lenCur;
  logic [CNT_W-1:0] lenNext;
  logic [CNT_W-1:0] cntNext;

  assign boundary = last1;

  // Strobes are computed from next-cycle values so they line up with the
  // m3cnt value they describe.
  always_comb begin
    lenNext = lenCur;
    if (idle || last1) lenNext = clampLen(stepLen);
    cntNext = '0;
    if (activeNext && !restart && !last1) cntNext = m3cnt + CNT_W'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      m3cnt  <= '0;
      lenCur <= LEN_MIN;
      first1 <= 1'b0;
      first2 <= 1'b0;
      last2  <= 1'b0;
      last1  <= 1'b0;
    end else begin
      m3cnt  <= cntNext;
      lenCur <= lenNext;
      first1 <= activeNext && (cntNext == '0);
      first2 <= activeNext && (cntNext == CNT_W'(1));
      last2  <= activeNext && (cntNext == lenNext - CNT_W'(2));
      last1  <= activeNext && (cntNext == lenNext - CNT_W'(1));
    end
  end

endmodule

// File: rtl/motoro3_step_sequencer.sv
// motoro3_step_sequencer
//   Timebase and commutation sequencer feeding the PWM generator. Steps the
//   12-position electrical index and lets stops finish on whole cycles.
//   clk : 10 MHz system clock, state changes on the falling edge
//   rst : async active-high reset
//   bus : slave side of motoro3_step_sequencer_if (requests, step config,
//         sgStep / m3cnt / strobes / pwmActive1 / pwmLENpos / cycleDone)
//
//   state    | meaning
//   IDLE     | outputs parked, config tracked every clock
//   RUN      | stepping, stopReq moves to STOPPING
//   STOPPING | stepping until the cycle end, startReq cancels the stop
module motoro3_step_sequencer
  import motoro3_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  motoro3_step_sequencer_if.slave  bus
);

  seqState_t state;
  seqState_t stateNext;
  logic      dirCur;
  logic      boundary;
  logic      cycleEnd;
  logic      idle;
  logic      restart;
  logic      activeNext;

  // A cycle ends on the last clock of step 11 going forward, step 0 in reverse.
  assign cycleEnd = boundary && (dirCur ? (bus.sgStep == 4'd0) : (bus.sgStep == STEP_MAX));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (bus.startReq) stateNext = RUN;
      RUN:      if (bus.stopReq) stateNext = STOPPING;
      STOPPING: begin
        if (bus.startReq)  stateNext = RUN;
        else if (cycleEnd) stateNext = IDLE;
      end
      default:  stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.pwmActive1 = (state != IDLE);
    idle           = (state == IDLE);
    restart        = (state == IDLE) && (stateNext == RUN);
    activeNext     = (stateNext != IDLE);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.sgStep    <= 4'd0;
      bus.pwmLENpos <= 16'd0;
      bus.cycleDone <= 1'b0;
      dirCur        <= 1'b0;
    end else begin
      bus.cycleDone <= (state == STOPPING) && (stateNext == IDLE);
      if (idle || boundary) begin
        bus.pwmLENpos <= bus.m3r_posPerPwm;
        dirCur        <= bus.dirRev;
      end
      // The step just finished advances in the direction it was run with.
      if (!activeNext)   bus.sgStep <= 4'd0;
      else if (restart)  bus.sgStep <= bus.dirRev ? STEP_MAX : 4'd0;
      else if (boundary) bus.sgStep <= nextStep(bus.sgStep, dirCur);
    end
  end

  motoro3_step_timer uTimer (
    .clk        (clk),
    .rst        (rst),
    .idle       (idle),
    .restart    (restart),
    .activeNext (activeNext),
    .stepLen    (bus.m3r_stepLen),
    .m3cnt      (bus.m3cnt),
    .first1     (bus.m3cntFirst1),
    .first2     (bus.m3cntFirst2),
    .last2      (bus.m3cntLast2),
    .last1      (bus.m3cntLast1),
    .boundary   (boundary)
  );

endmodule
